// File: rtl/mux_scan_sequencer.sv
// Round-robin select sequencer for a 4:1 mux: steps the select lines over enabled
// channels, waits a settle time, captures the mux output and offers it on valid/ready.
module mux_scan_sequencer #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [3:0]         chan_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               mux_out,
  output logic               s0,
  output logic               s1,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               sample_bit,
  output logic [1:0]         sample_chan,
  output logic               busy,
  output logic               wrap
);

  localparam int unsigned CHAN_W = 2;
  localparam int unsigned NCHAN  = 4;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_e;

  state_e               state_q, state_d;
  logic [CHAN_W-1:0]    chan_q, chan_d;
  logic [NCHAN-1:0]     mask_q, mask_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 stop_pend_q, stop_pend_d;
  logic                 valid_q, valid_d;
  logic                 bit_q, bit_d;
  logic [CHAN_W-1:0]    schan_q, schan_d;
  logic                 busy_q, busy_d;
  logic                 wrap_q, wrap_d;

  logic                 start_ok;
  logic                 handshake;
  logic                 end_scan;

  function automatic logic [CHAN_W-1:0] lowest_chan(input logic [NCHAN-1:0] m);
    logic [CHAN_W-1:0] r;
    r = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (m[i]) r = CHAN_W'(i);
    end
    return r;
  endfunction

  function automatic logic [CHAN_W-1:0] highest_chan(input logic [NCHAN-1:0] m);
    logic [CHAN_W-1:0] r;
    r = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (m[i]) r = CHAN_W'(i);
    end
    return r;
  endfunction

  // Smallest forward offset wins; falls back to the current channel when it is the only one.
  function automatic logic [CHAN_W-1:0] next_chan(input logic [NCHAN-1:0] m,
                                                  input logic [CHAN_W-1:0] cur);
    logic [CHAN_W-1:0] r;
    logic [CHAN_W-1:0] idx;
    r = cur;
    for (int k = NCHAN - 1; k >= 1; k--) begin
      idx = cur + CHAN_W'(k);
      if (m[idx]) r = idx;
    end
    return r;
  endfunction

  assign start_ok  = start && (chan_mask != '0);
  assign handshake = (state_q == HOLD) && sample_ready;
  assign end_scan  = stop_pend_q || stop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      chan_q      <= '0;
      mask_q      <= '0;
      dwell_q     <= '0;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
      valid_q     <= 1'b0;
      bit_q       <= 1'b0;
      schan_q     <= '0;
      busy_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      mask_q      <= mask_d;
      dwell_q     <= dwell_d;
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
      valid_q     <= valid_d;
      bit_q       <= bit_d;
      schan_q     <= schan_d;
      busy_q      <= busy_d;
      wrap_q      <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = SETTLE;
      SETTLE:  if (cnt_q == '0) state_d = HOLD;
      HOLD:    if (sample_ready) state_d = end_scan ? IDLE : SETTLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs; stop only arms a pending flag so the in-flight sample completes.
  always_comb begin
    chan_d      = chan_q;
    mask_d      = mask_q;
    dwell_d     = dwell_q;
    cnt_d       = cnt_q;
    stop_pend_d = stop_pend_q;
    valid_d     = valid_q;
    bit_d       = bit_q;
    schan_d     = schan_q;
    wrap_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          mask_d      = chan_mask;
          dwell_d     = dwell;
          chan_d      = lowest_chan(chan_mask);
          cnt_d       = dwell;
          stop_pend_d = 1'b0;
        end
      end
      SETTLE: begin
        if (stop) stop_pend_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else begin
          valid_d = 1'b1;
          bit_d   = mux_out;
          schan_d = chan_q;
        end
      end
      HOLD: begin
        if (stop) stop_pend_d = 1'b1;
        if (handshake) begin
          valid_d = 1'b0;
          wrap_d  = (chan_q == highest_chan(mask_q));
          if (end_scan) begin
            stop_pend_d = 1'b0;
          end else begin
            chan_d = next_chan(mask_q, chan_q);
            cnt_d  = dwell_q;
          end
        end
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign s0           = chan_q[0];
  assign s1           = chan_q[1];
  assign sample_valid = valid_q;
  assign sample_bit   = bit_q;
  assign sample_chan  = schan_q;
  assign busy         = busy_q;
  assign wrap         = wrap_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer; the bench plays the 4:1 mux from a 4-bit input pattern.
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [3:0] chan_mask;
  logic [7:0] dwell;
  logic       mux_out;
  logic       s0;
  logic       s1;
  logic       sample_valid;
  logic       sample_ready;
  logic       sample_bit;
  logic [1:0] sample_chan;
  logic       busy;
  logic       wrap;
  logic [3:0] din;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign mux_out = din[{s1, s0}];

  mux_scan_sequencer #(.DWELL_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .chan_mask    (chan_mask),
    .dwell        (dwell),
    .mux_out      (mux_out),
    .s0           (s0),
    .s1           (s1),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_bit   (sample_bit),
    .sample_chan  (sample_chan),
    .busy         (busy),
    .wrap         (wrap)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic start_scan(input logic [3:0] m, input logic [7:0] d);
    chan_mask = m;
    dwell     = d;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  // Called just after the edge that selected chan; returns with the sample presented.
  task automatic run_sample(input int chan, input int bitv, input int dw, input int wrp);
    for (int c = 0; c <= dw; c++) begin
      check("settle_valid", 32'(sample_valid), 0);
      check("settle_sel", 32'({s1, s0}), 32'(chan));
      check("settle_busy", 32'(busy), 1);
      check(c == 0 ? "wrap_pulse" : "wrap_low", 32'(wrap), c == 0 ? 32'(wrp) : 0);
      step();
    end
    check("sample_valid", 32'(sample_valid), 1);
    check("sample_chan", 32'(sample_chan), 32'(chan));
    check("sample_bit", 32'(sample_bit), 32'(bitv));
    check("hold_sel", 32'({s1, s0}), 32'(chan));
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    stop         = 1'b0;
    chan_mask    = 4'h0;
    dwell        = 8'd0;
    sample_ready = 1'b0;
    din          = 4'b0101;
    step();
    step();
    rst_n = 1'b1;

    // Idle after reset: every output low.
    for (int i = 0; i < 10; i++) begin
      check("idle_outputs", 32'({s1, s0, sample_valid, sample_bit, sample_chan, busy, wrap}), 0);
      step();
    end

    // Full mask, dwell 3, a=1 b=0 c=1 d=0, ready high: one sample per 5 cycles.
    din          = 4'b0101;
    sample_ready = 1'b1;
    start_scan(4'hF, 8'd3);
    run_sample(0, 1, 3, 0); step();
    run_sample(1, 0, 3, 0); step();
    run_sample(2, 1, 3, 0); step();
    run_sample(3, 0, 3, 0); step();
    run_sample(0, 1, 3, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_hs_busy", 32'(busy), 0);
    check("stop_hs_valid", 32'(sample_valid), 0);
    check("stop_hs_wrap", 32'(wrap), 0);
    check("stop_hs_sel", 32'({s1, s0}), 0);
    step();
    check("idle_busy", 32'(busy), 0);
    check("idle_valid", 32'(sample_valid), 0);

    // Sparse mask 1010, dwell 0: channels 1,3 alternate every 2 cycles.
    din = 4'b1000;
    start_scan(4'hA, 8'd0);
    run_sample(1, 0, 0, 0); step();
    run_sample(3, 1, 0, 0); step();
    run_sample(1, 0, 0, 1); step();
    run_sample(3, 1, 0, 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("sparse_end_busy", 32'(busy), 0);
    check("sparse_end_wrap", 32'(wrap), 1);
    check("sparse_end_sel", 32'({s1, s0}), 3);
    step();
    check("sparse_wrap_once", 32'(wrap), 0);

    // Backpressure: sample and select held while the mux input toggles.
    din          = 4'b0101;
    sample_ready = 1'b0;
    start_scan(4'hF, 8'd1);
    run_sample(0, 1, 1, 0);
    for (int i = 0; i < 7; i++) begin
      din = din ^ 4'hF;
      step();
      check("bp_valid", 32'(sample_valid), 1);
      check("bp_bit", 32'(sample_bit), 1);
      check("bp_chan", 32'(sample_chan), 0);
      check("bp_sel", 32'({s1, s0}), 0);
    end
    din          = 4'b0101;
    sample_ready = 1'b1;
    step();
    sample_ready = 1'b0;
    run_sample(1, 0, 1, 0);
    sample_ready = 1'b1;
    step();
    sample_ready = 1'b0;

    // Stop during SETTLE of channel 2: its sample still arrives, then the scan ends.
    check("stop_settle_sel", 32'({s1, s0}), 2);
    check("stop_settle_valid", 32'(sample_valid), 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_pend_valid", 32'(sample_valid), 0);
    check("stop_pend_busy", 32'(busy), 1);
    step();
    check("stop_last_valid", 32'(sample_valid), 1);
    check("stop_last_chan", 32'(sample_chan), 2);
    check("stop_last_bit", 32'(sample_bit), 1);
    sample_ready = 1'b1;
    step();
    check("stop_done_busy", 32'(busy), 0);
    check("stop_done_valid", 32'(sample_valid), 0);
    step();
    step();
    check("stop_quiet_valid", 32'(sample_valid), 0);
    check("stop_quiet_busy", 32'(busy), 0);
    sample_ready = 1'b0;

    // Start with an empty mask is ignored.
    start_scan(4'h0, 8'd2);
    check("mask0_busy", 32'(busy), 0);
    check("mask0_valid", 32'(sample_valid), 0);
    check("mask0_sel", 32'({s1, s0}), 2);

    // Start and stop together in IDLE: the scan still runs.
    stop = 1'b1;
    start_scan(4'hF, 8'd2);
    stop = 1'b0;
    run_sample(0, 1, 2, 0);
    step();
    step();
    check("hold_valid", 32'(sample_valid), 1);

    // Reset while holding a sample.
    rst_n = 1'b0;
    step();
    check("rst_valid", 32'(sample_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sel", 32'({s1, s0}), 0);
    check("rst_data", 32'({sample_bit, sample_chan}), 0);
    rst_n = 1'b1;
    step();

    // Restart after reset: first sample after dwell+1 cycles.
    start_scan(4'h4, 8'd2);
    run_sample(2, 1, 2, 0);
    sample_ready = 1'b1;
    stop         = 1'b1;
    step();
    stop         = 1'b0;
    sample_ready = 1'b0;
    check("restart_end_busy", 32'(busy), 0);
    check("restart_end_wrap", 32'(wrap), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
# mux_scan_sequencer

Round-robin select sequencer that sits directly upstream of the 4:1 `multiplexer`. It drives the mux select lines `s1`/`s0`, waits a programmable settle time on each enabled channel, captures the mux `out` bit, and presents it with its channel number on a valid/ready output. This turns the combinational 4:1 mux into a scanned 4-channel bit sampler.

## Interface

Parameters:
- `DWELL_W`, default 8: width of the settle-count input and the internal counter.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  start-scan request, sampled each edge.
- `stop`  in  1  stop-scan request, sampled each edge.
- `chan_mask`  in  4  channel enables, bit i = mux input i (0=a, 1=b, 2=c, 3=d); latched on accepted `start`.
- `dwell`  in  DWELL_W  settle count; latched on accepted `start`.
- `mux_out`  in  1  connected to the mux `out`.
- `s0`  out  1  mux select bit 0 (channel index bit 0).
- `s1`  out  1  mux select bit 1 (channel index bit 1).
- `sample_valid`  out  1  a captured sample is presented.
- `sample_ready`  in  1  downstream accepts the sample.
- `sample_bit`  out  1  captured `mux_out` value.
- `sample_chan`  out  2  channel index of `sample_bit`.
- `busy`  out  1  high in any state other than IDLE.
- `wrap`  out  1  one-cycle pulse on a completed handshake of the highest enabled channel.

## Operation

- States: IDLE, SETTLE, HOLD.
- IDLE: `start`=1 with `chan_mask`!=0 latches mask and dwell. It selects the lowest enabled channel, loads the counter with dwell, clears stop_pending and goes to SETTLE. If `start`=1 with mask=0, the block stays in IDLE with no outputs changed. `stop` is ignored in IDLE, including when it arrives in the same cycle as `start`, so the scan starts.
- SETTLE: when counter!=0, decrement it. When counter==0, sample_bit<=mux_out, sample_chan<=current index, sample_valid<=1, then go to HOLD.
- HOLD: `sample_valid`, `sample_bit` and `sample_chan` are held stable until `sample_ready`=1. On the handshake edge:
  - drop `sample_valid`;
  - if the handshake was for the highest enabled channel, pulse `wrap` for the following cycle;
  - if stop_pending, go to IDLE;
  - otherwise select the next enabled channel in ascending order, wrapping from 3 to the lowest enabled, reload the counter and go to SETTLE.
  With a single enabled channel, the scan re-selects the same channel.
- `stop`=1 in SETTLE or HOLD sets stop_pending. The in-flight sample still completes its handshake. A handshake in the same cycle as `stop` also ends the scan.
- `start` while `busy` is ignored. Changes to `chan_mask`/`dwell` during a scan have no effect.
- `{s1,s0}` = current channel index. It changes only on entry to SETTLE and is stable through SETTLE and HOLD. In IDLE it keeps its last value.
- Counter is DWELL_W bits unsigned; no wrap is possible because it loads and counts down to 0.

## Timing

- Reset: `s0`=`s1`=0, `sample_valid`=0, `sample_bit`=0, `sample_chan`=0, `busy`=0, `wrap`=0, state IDLE, stop_pending=0.
- Reset in the middle of a scan drops `sample_valid` without a handshake and returns to IDLE on the reset edge.
- Start accepted at edge E0: `busy`=1 and new select from E0. `sample_valid` rises after edge E0+dwell+1, so the mux settles for dwell+1 cycles.
- `mux_out` is sampled at the edge where counter==0, i.e. dwell+1 cycles after the select changed.
- Handshake at edge Eh: next select and `sample_valid`=0 from Eh. Next `sample_valid` rises after Eh+dwell+1.
- Throughput with `sample_ready` held high: one sample per dwell+2 cycles.
- On the final handshake with stop_pending, `busy` falls after that edge.
- `wrap` is high for exactly the one cycle after the qualifying handshake edge.

## Test plan

- Reset, then idle with `start`=0 -> all outputs 0 for 10 cycles.
- mask=4'b1111, dwell=3, a=1, b=0, c=1, d=0, ready=1 -> samples (chan,bit) = (0,1),(1,0),(2,1),(3,0),(0,1)…, each 5 cycles apart; `wrap` pulses after each chan-3 handshake; selects stable for the 5 cycles of each sample.
- mask=4'b1010, dwell=0, ready=1 -> channels 1,3,1,3 every 2 cycles; `{s1,s0}` is never 00 or 10 after start.
- Backpressure: ready=0 for 7 cycles in HOLD -> valid, bit and chan held constant and the select stays unchanged while `mux_out` toggles; ready=1 -> advances exactly one channel.
- `stop` pulse during SETTLE of chan 2 -> chan 2 sample still delivered, then `busy`=0 and no further valid. `start` with mask=0 -> stays IDLE. `start`+`stop` together in IDLE -> scan runs.
- `rst_n`=0 while in HOLD with valid=1 -> next cycle valid=0, busy=0, `{s1,s0}`=00. Then restart -> first sample arrives after dwell+1 cycles.
